ifq_line_queue: RTL and testbench
=================================

Name: ifq_line_queue

Overview:
- Parametrised instruction fetch queue that sits between the I-cache line fill path and the decode/dispatch stage.
- Buffers whole cache lines, each tagged with its line PC, and hands them out one instruction per pop, together with that instruction's PC.
- A branch/jump redirect flushes the queue and sets a start-word offset inside the first line to arrive.
- Next generation of the IFQ FIFO: generalised line, instruction and depth widths, with proper wrap-around full/empty, an occupancy count, PC tagging and deterministic empty output.

Parameters:
- LINE_WIDTH, 128, cache line width in bits; must be a multiple of INSTR_WIDTH.
- INSTR_WIDTH, 32, instruction width in bits.
- DEPTH, 4, number of line entries; power of two, at least 2.
- PC_WIDTH, 32, PC width in bits.
- Derived localparams (not overridable):
  - WPL = LINE_WIDTH/INSTR_WIDTH, words per line.
  - OW = clog2(WPL), offset width.
  - AW = clog2(DEPTH), entry address width.
  - IB = INSTR_WIDTH/8, bytes per instruction.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- line_valid, input, 1, a cache line is presented for write.
- line_data, input, LINE_WIDTH, line contents; word 0 is in the LSBs.
- line_pc, input, PC_WIDTH, byte address of word 0 of the line.
- line_ready, output, 1, the queue accepts a line this cycle.
- flush, input, 1, redirect: discard all contents.
- flush_offset, input, OW, start-word index within the next line.
- instr_valid, output, 1, instr and instr_pc are valid.
- instr, output, INSTR_WIDTH, current head instruction.
- instr_pc, output, PC_WIDTH, PC of the current head instruction.
- instr_pop, input, 1, consume the head instruction.
- full, output, 1, all DEPTH entries occupied.
- empty, output, 1, no entries occupied.
- count, output, AW+1, number of occupied line entries, 0..DEPTH.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each AW+1 bits (extra MSB is the wrap bit).
  - woff, OW bits: word offset within the head line.
  - Line memory of DEPTH x LINE_WIDTH and PC memory of DEPTH x PC_WIDTH; neither memory is reset.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, woff = 0.
  - empty = 1, full = 0, count = 0, line_ready = 1.
  - instr_valid = 0, instr = 0, instr_pc = 0.
- Status signals, all derived from registered pointers only, with no input-to-output combinational paths except through instr_pop/line_valid effects on the next state:
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) and (wr_ptr[AW] != rd_ptr[AW]).
  - count = wr_ptr - rd_ptr, computed modulo 2^(AW+1).
- Write:
  - Occurs when line_valid && line_ready.
  - line_ready = !full.
  - The line and PC are stored at wr_ptr[AW-1:0]; wr_ptr increments.
  - Because full is registered, a pop that frees an entry cannot enable a write in the same cycle; the write is accepted on the next cycle.
- Read outputs:
  - instr_valid = !empty.
  - instr = word woff of the head entry.
  - instr_pc = head PC + woff*IB, truncated to PC_WIDTH.
  - When empty, instr and instr_pc are driven to 0.
- Pop:
  - Has effect only when instr_pop && instr_valid; a pop while empty is ignored with no state change.
  - If woff == WPL-1: woff wraps to 0 and rd_ptr increments, freeing the entry.
  - Otherwise: woff increments.
- Simultaneous write and pop (not full, not empty):
  - Both take effect.
  - count stays unchanged if the pop retires a line; otherwise count increments.
- Flush has priority over write and pop:
  - rd_ptr = 0 and woff = flush_offset.
  - If line_valid is also high that cycle, the line is written to entry 0 and wr_ptr = 1; line_ready is treated as 1 during the flush cycle regardless of full.
  - Otherwise wr_ptr = 0, so the queue is empty; the next accepted line goes to entry 0 and is read from flush_offset.
- Pointer wrap: pointers wrap naturally modulo 2^(AW+1); full and empty remain correct across any number of wraps.
- Reset mid-operation: all state returns to reset values immediately and asynchronously; a line presented in the same cycle is lost.

Decomposition:
- Shared package ifq_pkg holds:
  - Default constants IFQ_LINE_WIDTH, IFQ_INSTR_WIDTH, IFQ_DEPTH.
  - Typedef ifq_entry_t, a struct of line and pc.
- The line/PC storage is natural as a sub-module, ifq_line_ram: DEPTH x (LINE_WIDTH+PC_WIDTH), one synchronous write port, one combinational read port.
- Pointer, offset and status logic stay in the top level.

Test Plan:
- Reset, then write lines with PC 0x100 and 0x110 (words 0xA0..0xA3, 0xB0..0xB3), then pop 8 times. Required: instr/instr_pc sequence 0xA0/0x100 .. 0xA3/0x10C, 0xB0/0x110 .. 0xB3/0x11C; then empty = 1 and instr = 0.
- Fill 4 lines with no pops. Required: full = 1, count = 4, line_ready = 0; a 5th line_valid is dropped. After 4 pops, count = 3 and line_ready = 1 on the following cycle.
- Run 10 write/4-pop rounds, so pointers wrap at least twice. Required: data order is preserved and count never exceeds 4 or underflows.
- With 2 lines queued, mid-line, assert flush with flush_offset = 2 and line_valid carrying PC 0x200 (words 0xC0..0xC3). Required: next cycle instr = 0xC2, instr_pc = 0x208, count = 1.
- Assert flush with flush_offset = 3 and no line_valid. Required: empty = 1. The next line, PC 0x300, then yields instr_pc = 0x30C; one pop then empties the queue.
- On a non-full, non-empty queue with woff = 3, assert a write and a pop together. Required: count is unchanged and the head advances to the next line at woff = 0. A pop while empty causes no state change.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared defaults and types for the instruction fetch line queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifq_pkg;

    localparam int IFQ_LINE_WIDTH  = 128;
    localparam int IFQ_INSTR_WIDTH = 32;
    localparam int IFQ_DEPTH       = 4;
    localparam int IFQ_PC_WIDTH    = 32;

    // One queue entry: a whole cache line tagged with the byte PC of word 0.
    typedef struct packed {
        logic [IFQ_PC_WIDTH-1:0]   pc;
        logic [IFQ_LINE_WIDTH-1:0] line;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_line_ram.sv
// Line + PC storage for the fetch queue: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge; read is same-cycle.
// Backpressure: none; the caller only writes when a slot is free (or on a redirect).
module ifq_line_ram #(
    parameter int DEPTH      = 4,
    parameter int LINE_WIDTH = 128,
    parameter int PC_WIDTH   = 32,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [LINE_WIDTH-1:0] wr_line,
    input  logic [PC_WIDTH-1:0]   wr_pc,
    input  logic [AW-1:0]         rd_addr,
    output logic [LINE_WIDTH-1:0] rd_line,
    output logic [PC_WIDTH-1:0]   rd_pc
);

    // Storage is deliberately not reset: the pointers decide what is valid.
    logic [PC_WIDTH+LINE_WIDTH-1:0] mem [DEPTH];

    // Capture line and its PC together into the addressed slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_pc, wr_line};
        end
    end

    assign rd_line = mem[rd_addr][LINE_WIDTH-1:0];
    assign rd_pc   = mem[rd_addr][PC_WIDTH+LINE_WIDTH-1:LINE_WIDTH];

endmodule

// File: rtl/ifq_line_queue.sv
// Instruction fetch queue: buffers PC-tagged cache lines, hands out one instruction (and its PC) per pop.
// Latency: an accepted line is visible at the head the cycle after the write; head output is combinational from state.
// Backpressure: line_ready = !full from registered pointers; a pop freeing a slot enables a write only on the next cycle.
module ifq_line_queue
    import ifq_pkg::*;
#(
    parameter int LINE_WIDTH  = IFQ_LINE_WIDTH,
    parameter int INSTR_WIDTH = IFQ_INSTR_WIDTH,
    parameter int DEPTH       = IFQ_DEPTH,
    parameter int PC_WIDTH    = IFQ_PC_WIDTH,
    localparam int WPL        = LINE_WIDTH / INSTR_WIDTH,
    localparam int OW         = $clog2(WPL),
    localparam int AW         = $clog2(DEPTH),
    localparam int IB         = INSTR_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_valid,
    input  logic [LINE_WIDTH-1:0]  line_data,
    input  logic [PC_WIDTH-1:0]    line_pc,
    output logic                   line_ready,
    input  logic                   flush,
    input  logic [OW-1:0]          flush_offset,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   instr_pop,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            count
);

    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
    localparam logic [OW-1:0] OFF_ONE  = OW'(1);
    localparam logic [OW-1:0] OFF_LAST = OW'(WPL - 1);

    // Pointers carry an extra wrap bit so full and empty stay distinguishable.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [OW-1:0] woff;

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic                  pop_en;
    logic                  last_word;
    logic [LINE_WIDTH-1:0] head_line;
    logic [PC_WIDTH-1:0]   head_pc;
    logic [INSTR_WIDTH-1:0] head_words [WPL];

    // Status comes only from registered pointers.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count       = wr_ptr - rd_ptr;
    assign line_ready  = !full;
    assign instr_valid = !empty;

    // A redirect always takes the presented line into slot 0, even when the queue was full.
    assign wr_en     = line_valid && (flush || !full);
    assign wr_addr   = flush ? '0 : wr_ptr[AW-1:0];
    assign pop_en    = instr_pop && !empty;
    assign last_word = (woff == OFF_LAST);

    ifq_line_ram #(
        .DEPTH      (DEPTH),
        .LINE_WIDTH (LINE_WIDTH),
        .PC_WIDTH   (PC_WIDTH)
    ) u_line_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_line (line_data),
        .wr_pc   (line_pc),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_line (head_line),
        .rd_pc   (head_pc)
    );

    // Split the head line into instruction words, word 0 in the LSBs.
    for (genvar g = 0; g < WPL; g++) begin : g_words
        assign head_words[g] = head_line[g*INSTR_WIDTH +: INSTR_WIDTH];
    end

    // Head instruction and its PC; forced to zero when nothing is queued.
    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (!empty) begin
            instr    = head_words[woff];
            instr_pc = head_pc + PC_WIDTH'(woff) * PC_WIDTH'(IB);
        end
    end

    // Pointer and offset update; a redirect overrides any write or pop that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            woff   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            woff   <= flush_offset;
            wr_ptr <= line_valid ? PTR_ONE : '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_en) begin
                if (last_word) begin
                    woff   <= '0;
                    rd_ptr <= rd_ptr + PTR_ONE;
                end else begin
                    woff <= woff + OFF_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifq_line_queue.sv
// Self-checking bench for ifq_line_queue: scoreboard of expected instruction/PC pairs.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: model applies the same accept rule (line_valid && (flush || not full)).
module tb_ifq_line_queue;

    logic         clk;
    logic         rst;
    logic         line_valid;
    logic [127:0] line_data;
    logic [31:0]  line_pc;
    logic         line_ready;
    logic         flush;
    logic [1:0]   flush_offset;
    logic         instr_valid;
    logic [31:0]  instr;
    logic [31:0]  instr_pc;
    logic         instr_pop;
    logic         full;
    logic         empty;
    logic [2:0]   count;

    ifq_line_queue #(
        .LINE_WIDTH  (128),
        .INSTR_WIDTH (32),
        .DEPTH       (4),
        .PC_WIDTH    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .line_valid   (line_valid),
        .line_data    (line_data),
        .line_pc      (line_pc),
        .line_ready   (line_ready),
        .flush        (flush),
        .flush_offset (flush_offset),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_pop    (instr_pop),
        .full         (full),
        .empty        (empty),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        bit          last;
    } exp_t;

    exp_t     sb[$];
    int       m_cnt;
    int       start_off;
    int       n_cmp;
    int       n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    // Compare every output against the model state.
    task automatic check_outputs();
        chk("count", count, m_cnt);
        chk("empty", empty, m_cnt == 0);
        chk("full", full, m_cnt == 4);
        chk("line_ready", line_ready, m_cnt != 4);
        chk("instr_valid", instr_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            chk("instr", instr, sb[0].ins);
            chk("instr_pc", instr_pc, sb[0].pc);
        end else begin
            chk("instr_empty_zero", instr, 0);
            chk("pc_empty_zero", instr_pc, 0);
        end
    endtask

    task automatic push_line(input logic [31:0] base, input logic [31:0] pc);
        for (int i = start_off; i < 4; i++) begin
            exp_t e;
            e.ins  = base + 32'(i);
            e.pc   = pc + 32'(i * 4);
            e.last = (i == 3);
            sb.push_back(e);
        end
        start_off = 0;
    endtask

    // One clock: check, drive, update model, advance to next falling edge.
    task automatic cycle(input bit lv, input logic [31:0] base, input logic [31:0] pc,
                         input bit fl, input logic [1:0] foff, input bit pop);
        bit   accept;
        exp_t e;
        check_outputs();
        line_valid   = lv;
        line_data    = mk_line(base);
        line_pc      = pc;
        flush        = fl;
        flush_offset = foff;
        instr_pop    = pop;
        accept = lv && (fl || m_cnt < 4);
        if (fl) begin
            sb.delete();
            m_cnt     = 0;
            start_off = int'(foff);
            if (accept) begin
                push_line(base, pc);
                m_cnt = 1;
            end
        end else begin
            if (pop && sb.size() != 0) begin
                e = sb.pop_front();
                if (e.last) m_cnt--;
            end
            if (accept) begin
                push_line(base, pc);
                m_cnt++;
            end
        end
        @(negedge clk);
        line_valid = 1'b0;
        flush      = 1'b0;
        instr_pop  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] base, input logic [31:0] pc);
        cycle(1'b1, base, pc, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic pop1();
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 32 && sb.size() != 0; i++) pop1();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; m_cnt = 0; start_off = 0;
        rst = 1'b1;
        line_valid = 1'b0; line_data = '0; line_pc = '0;
        flush = 1'b0; flush_offset = '0; instr_pop = 1'b0;

        // Reset state
        #3;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_line_ready", line_ready, 1);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Two lines, eight pops, in-order instruction and PC sequence
        wr(32'hA0, 32'h100);
        wr(32'hB0, 32'h110);
        chk("t1_first", instr, 32'hA0);
        for (int i = 0; i < 8; i++) pop1();
        chk("t1_empty", empty, 1);
        chk("t1_instr0", instr, 0);

        // Fill to full, drop a fifth line, then free one entry
        for (int i = 0; i < 4; i++) wr(32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16));
        chk("t2_full", full, 1);
        chk("t2_count", count, 4);
        chk("t2_not_ready", line_ready, 0);
        wr(32'hDEAD0, 32'h9990);
        chk("t2_count_drop", count, 4);
        for (int i = 0; i < 4; i++) pop1();
        chk("t2_count3", count, 3);
        chk("t2_ready", line_ready, 1);
        drain();

        // Ten write/4-pop rounds, pointers wrap repeatedly
        for (int r = 0; r < 10; r++) begin
            wr(32'h3000 + 32'(r * 16), 32'h4000 + 32'(r * 16));
            for (int i = 0; i < 4; i++) pop1();
        end
        chk("t3_empty", empty, 1);

        // Flush mid-line with a new line and offset 2
        wr(32'h10, 32'h1000);
        wr(32'h20, 32'h1010);
        pop1();
        cycle(1'b1, 32'hC0, 32'h200, 1'b1, 2'd2, 1'b0);
        chk("t4_instr", instr, 32'hC2);
        chk("t4_pc", instr_pc, 32'h208);
        chk("t4_count", count, 1);
        drain();

        // Flush with no line, offset applies to the next arrival
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 2'd3, 1'b0);
        chk("t5_empty", empty, 1);
        wr(32'hD0, 32'h300);
        chk("t5_pc", instr_pc, 32'h30C);
        chk("t5_instr", instr, 32'hD3);
        pop1();
        chk("t5_empty2", empty, 1);

        // Pop while empty changes nothing
        pop1();
        pop1();
        chk("t6_empty_pop", count, 0);
        wr(32'hE0, 32'h400);
        chk("t6_head", instr, 32'hE0);
        drain();

        // Simultaneous write and line-retiring pop at woff = 3
        wr(32'hF0, 32'h500);
        wr(32'h60, 32'h510);
        pop1(); pop1(); pop1();
        chk("t7_pre_count", count, 2);
        cycle(1'b1, 32'h70, 32'h520, 1'b0, 2'd0, 1'b1);
        chk("t7_count", count, 2);
        chk("t7_head", instr, 32'h60);
        chk("t7_head_pc", instr_pc, 32'h510);
        // Write and non-retiring pop together: count grows
        cycle(1'b1, 32'h80, 32'h530, 1'b0, 2'd0, 1'b1);
        chk("t7_count_inc", count, 3);

        // Asynchronous reset mid-operation
        #2;
        rst = 1'b1;
        #1;
        chk("t8_empty", empty, 1);
        chk("t8_count", count, 0);
        chk("t8_valid", instr_valid, 0);
        sb.delete(); m_cnt = 0; start_off = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Random mix of writes, pops and occasional redirects
        for (int n = 0; n < 400; n++) begin
            logic [31:0] b;
            logic [31:0] p;
            b = $urandom;
            p = $urandom & 32'hFFFF_FFF0;
            cycle($urandom_range(0, 1) == 1, b, p, $urandom_range(0, 19) == 0,
                  2'($urandom_range(0, 3)), $urandom_range(0, 9) < 6);
        end
        drain();
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
